// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned BYTES_PER_WORD   = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch buffer of assembled words; head is driven straight from storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  // A push into a full buffer is accepted only when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: assembles big-endian words from a byte-wide imem, buffers them
// with their PCs and hands them to the core; redirects flush and restart fetch.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd_en,
  input  logic [7:0]        imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_data,
  output logic [31:0]       inst_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              fetch_err
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [31:0]  fpc_q, fpc_d;
  logic [1:0]   byte_cnt_q, byte_cnt_d;
  logic [23:0]  asm_q, asm_d;
  logic         fetch_err_q, fetch_err_d;

  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_flush;
  logic         fifo_full;
  logic         fifo_empty;
  fetch_entry_t push_entry;
  fetch_entry_t head;

  // Reading starts as soon as reset is released so the first byte lands on the first edge.
  assign imem_rd_en = rst_n && !fetch_err_q;
  assign imem_addr  = ADDR_W'(fpc_q + 32'(byte_cnt_q));
  assign fetch_err  = fetch_err_q;

  assign fifo_pop   = !fifo_empty && inst_ready;
  assign inst_valid = !fifo_empty;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

  always_comb begin
    fpc_d       = fpc_q;
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    fetch_err_d = fetch_err_q;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    push_entry  = '{pc: fpc_q, inst: {asm_q, imem_rdata}};
    if (redirect_valid) begin
      fifo_flush = 1'b1;
      byte_cnt_d = '0;
      asm_d      = '0;
      if (is_word_aligned(redirect_pc)) begin
        fpc_d       = redirect_pc;
        fetch_err_d = 1'b0;
      end else begin
        fetch_err_d = 1'b1;
      end
    end else if (imem_rd_en) begin
      if (byte_cnt_q == LAST_BYTE) begin
        // Stall on the last byte when the buffer cannot take the word.
        if (!fifo_full || fifo_pop) begin
          fifo_push  = 1'b1;
          fpc_d      = fpc_q + 32'(BYTES_PER_WORD);
          byte_cnt_d = '0;
        end
      end else begin
        case (byte_cnt_q)
          2'd0:    asm_d[23:16] = imem_rdata;
          2'd1:    asm_d[15:8]  = imem_rdata;
          default: asm_d[7:0]   = imem_rdata;
        endcase
        byte_cnt_d = byte_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_q       <= RESET_PC;
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      fpc_q       <= fpc_d;
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .pop        (fifo_pop),
    .flush      (fifo_flush),
    .push_entry (push_entry),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (head)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit against a 32-byte behavioural imem.
module tb_fetch_prefetch_unit;

  logic        clk;
  logic        rst_n;
  logic [4:0]  imem_addr;
  logic        imem_rd_en;
  logic [7:0]  imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  logic [7:0]  mem [32];
  int          total = 0;
  int          bad   = 0;

  fetch_prefetch_unit #(
    .ADDR_W   (5),
    .DEPTH    (2),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rd_en     (imem_rd_en),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  assign imem_rdata = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step(1);
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h40 + i);
    mem[0] = 8'h8C; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h04;

    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(2);
    check("rst_valid",  32'(inst_valid), 32'd0);
    check("rst_data",   inst_data,       32'h0);
    check("rst_pc",     inst_pc,         32'h0);
    check("rst_addr",   32'(imem_addr),  32'h0);
    check("rst_rd_en",  32'(imem_rd_en), 32'd0);
    check("rst_err",    32'(fetch_err),  32'd0);

    // Reset release: first word after the 4th edge, next one 4 edges later.
    rst_n = 1'b1;
    #1 check("rel_rd_en", 32'(imem_rd_en), 32'd1);
    step(3);
    check("lat3_valid", 32'(inst_valid), 32'd0);
    step(1);
    check("w0_valid", 32'(inst_valid), 32'd1);
    check("w0_data",  inst_data,       32'h8C01_0004);
    check("w0_pc",    inst_pc,         32'h0);
    step(1);
    check("w0_popped", 32'(inst_valid), 32'd0);
    step(3);
    check("w1_valid", 32'(inst_valid), 32'd1);
    check("w1_pc",    inst_pc,         32'h4);
    check("w1_data",  inst_data,       32'h4445_4647);

    // Backpressure: buffer fills with pc 0 and 4, fetch parks on byte 3 of pc 8.
    inst_ready = 1'b0;
    redirect(32'h0);
    check("bp_flush_valid", 32'(inst_valid), 32'd0);
    check("bp_flush_addr",  32'(imem_addr),  32'h0);
    step(20);
    check("bp_head_pc", inst_pc,        32'h0);
    check("bp_addr",    32'(imem_addr), 32'h0B);
    step(1);
    check("bp_addr_hold", 32'(imem_addr), 32'h0B);
    inst_ready = 1'b1;
    step(1);
    check("drain1_pc",   inst_pc,   32'h4);
    check("drain1_data", inst_data, 32'h4445_4647);
    step(1);
    check("drain2_pc",   inst_pc,   32'h8);
    check("drain2_data", inst_data, 32'h4849_4A4B);
    check("drain2_valid", 32'(inst_valid), 32'd1);

    // Redirect in the middle of a word.
    redirect(32'h0);
    step(2);
    redirect(32'h10);
    check("rd10_valid", 32'(inst_valid), 32'd0);
    check("rd10_addr",  32'(imem_addr),  32'h10);
    step(3);
    check("rd10_lat3", 32'(inst_valid), 32'd0);
    step(1);
    check("rd10_pc",   inst_pc,   32'h10);
    check("rd10_data", inst_data, 32'h5051_5253);

    // Index wrap past the top of imem.
    redirect(32'h1C);
    step(4);
    check("rd1c_pc",   inst_pc,        32'h1C);
    check("rd1c_data", inst_data,      32'h5C5D_5E5F);
    check("wrap_addr", 32'(imem_addr), 32'h00);
    step(4);
    check("wrap_pc",   inst_pc,   32'h20);
    check("wrap_data", inst_data, 32'h8C01_0004);

    // Misaligned redirect halts fetch until an aligned one arrives.
    redirect(32'h06);
    check("mis_err",   32'(fetch_err),  32'd1);
    check("mis_rd_en", 32'(imem_rd_en), 32'd0);
    check("mis_valid", 32'(inst_valid), 32'd0);
    step(6);
    check("mis_hold_valid", 32'(inst_valid), 32'd0);
    check("mis_hold_err",   32'(fetch_err),  32'd1);
    redirect(32'h08);
    check("rec_err",   32'(fetch_err),  32'd0);
    check("rec_rd_en", 32'(imem_rd_en), 32'd1);
    step(3);
    check("rec_lat3", 32'(inst_valid), 32'd0);
    step(1);
    check("rec_pc",   inst_pc,   32'h8);
    check("rec_data", inst_data, 32'h4849_4A4B);

    // Asynchronous reset mid-word with one word buffered.
    inst_ready = 1'b0;
    redirect(32'h0);
    step(6);
    check("pre_rst_valid", 32'(inst_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 check("arst_valid", 32'(inst_valid), 32'd0);
    check("arst_data", inst_data, 32'h0);
    check("arst_addr", 32'(imem_addr), 32'h0);
    #1 rst_n = 1'b1;
    inst_ready = 1'b1;
    step(3);
    check("arst_lat3", 32'(inst_valid), 32'd0);
    step(1);
    check("arst_pc",   inst_pc,   32'h0);
    check("arst_data2", inst_data, 32'h8C01_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
